umem_fetch_arbiter: RTL and testbench
=====================================

Name: umem_fetch_arbiter

Overview:
Parametrised unified-memory front end for the next core generation. It replaces the separate instruction ROM and data RAM paths with one memory port. The block prefetches instructions into a queue and arbitrates between instruction fetch and load/store traffic. Data accesses have priority; fetch resumes from a redirect PC on jumps.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory word width; power of 2, at least IR_W
IR_W, 16, instruction width; PC step = IR_W/8 bytes
PFQ_DEPTH, 4, prefetch queue entries; power of 2, at least 2

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_redirect  in  1  flush queue, restart fetch at i_redirect_pc
i_redirect_pc  in  ADDR_W  new fetch PC; IR_W/8-aligned
o_ir_valid  out  1  queue head valid
o_ir  out  IR_W  head instruction
o_ir_pc  out  ADDR_W  head instruction address
i_ir_ready  in  1  consumer pops head when o_ir_valid & i_ir_ready
i_d_req  in  1  data access request; held until o_d_done
i_d_we  in  1  1 = store, 0 = load
i_d_addr  in  ADDR_W  DATA_W/8-aligned data address
i_d_wdata  in  DATA_W  store data
o_d_rdata  out  DATA_W  load data, valid with o_d_done
o_d_done  out  1  single-cycle completion pulse
o_mem_req  out  1  memory request, held until i_mem_ack
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  word-aligned memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  read data, valid with i_mem_ack
i_mem_ack  in  1  memory completes current request (any latency, at least 1 cycle)

Behaviour:
- Reset (asynchronous, i_rst=0): fetch PC = 0, queue empty, in-flight count 0, FSM IDLE, kill flag 0. All outputs read 0.
- FSM states: IDLE, FETCH, DATA. Only one memory request is outstanding at a time.
- IDLE -> DATA when i_d_req=1. This has priority over fetch.
- IDLE -> FETCH when i_d_req=0 and occupancy + in-flight < PFQ_DEPTH.
- FETCH -> IDLE on i_mem_ack. DATA -> IDLE on i_mem_ack. No back-to-back issue: at least one IDLE cycle separates requests.
- On entering FETCH: o_mem_addr = fetch PC with low log2(DATA_W/8) bits cleared; o_mem_we=0.
- On FETCH ack: push the IR_W slice of i_mem_rdata selected by the PC byte offset (little-endian; offset 0 = bits IR_W-1:0). Fetch PC += IR_W/8, wrapping modulo 2^ADDR_W.
- DATA ack: o_d_done=1 for one cycle, in the ack+1 cycle. o_d_rdata is registered from i_mem_rdata for loads and reads 0 for stores.
- The queue presents its head combinationally. Push and pop in the same cycle are both allowed, including at full or at the boundary.
- Redirect in the cycle it is asserted: queue cleared and fetch PC = i_redirect_pc.
  - If a FETCH is in flight, the kill flag is set; that response is dropped and the flag is cleared on its ack.
  - A same-cycle pop is discarded. A same-cycle ack is dropped.
  - A redirect has no effect on a DATA transaction.
- A redirect asserted again while the kill flag is set only updates the PC.
- An i_d_req arriving during FETCH waits for the ack and is then served before the next fetch.

Optional Feature:
Macro UMEM_PERF_EN.
- Defined: adds 32-bit outputs o_fetch_cnt (FETCH acks accepted), o_data_cnt (o_d_done pulses) and o_kill_cnt (responses dropped by redirect).
  - All three clear on reset and saturate at 0xFFFFFFFF.
- Undefined: these ports do not exist and no counter logic is built.

Test Plan:
- Reset release, i_ir_ready=0, memory ack latency 1, mem word 0x0 = 0xBBBBAAAA:
  - o_ir_valid rises with o_ir=0xAAAA, o_ir_pc=0.
  - Queue fills to 4 entries (PCs 0,2,4,6) and o_mem_req then stays 0.
- i_d_req load from 0x100 (mem 0x12345678) while a fetch is pending:
  - Data is issued first; o_d_done pulses once with o_d_rdata=0x12345678.
  - Fetch resumes afterwards.
- Store 0xDEADBEEF to 0x200: o_mem_we=1, o_mem_addr=0x200, o_mem_wdata=0xDEADBEEF; o_d_done pulses and o_d_rdata=0.
- Redirect to 0x40 with a fetch in flight and ack latency 3:
  - The in-flight word is dropped.
  - The first o_ir_pc after the redirect is 0x40, then 0x42.
- Full queue, simultaneous pop and fetch ack: occupancy is unchanged, with no overflow or lost entry.
- Assert i_rst low mid-DATA transaction: all outputs read 0 immediately. After release, fetch restarts at PC 0 and no o_d_done is seen.

Source files
------------

// File: rtl/umem_fetch_arbiter.sv
// Unified-memory front end: instruction prefetch queue plus data/fetch arbiter sharing one memory port.
// Optional macro UMEM_PERF_EN adds saturating fetch/data/kill event counters.
module umem_fetch_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int IR_W      = 16,
  parameter int PFQ_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_ir_valid,
  output logic [IR_W-1:0]   o_ir,
  output logic [ADDR_W-1:0] o_ir_pc,
  input  logic              i_ir_ready,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [1:0]        o_dbg_state
`ifdef UMEM_PERF_EN
  ,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_data_cnt,
  output logic [31:0]       o_kill_cnt
`endif
);

  // Handshakes: the queue head transfers when o_ir_valid & i_ir_ready at a clock edge;
  // o_mem_req holds its command stable until the edge where i_mem_ack is seen high;
  // i_d_req holds its command until the cycle o_d_done pulses.

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W = $clog2(PFQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(IR_W / 8);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              in_flight;
  logic              kill;
  logic              d_done_q;
  logic [IR_W-1:0]   q_ir [PFQ_DEPTH];
  logic [ADDR_W-1:0] q_pc [PFQ_DEPTH];

  logic              d_req_eff, fetch_room;
  logic              issue_data, issue_fetch;
  logic              fetch_ack, data_ack, fetch_drop, push, pop;
  logic [OFF_W-1:0]  byte_off;
  logic [IR_W-1:0]   fetch_ir;

  // The request is still high during its own done cycle; it must not start a second access.
  assign d_req_eff   = i_d_req & ~d_done_q;
  assign fetch_room  = (count + CNT_W'(in_flight)) < CNT_W'(PFQ_DEPTH);
  assign issue_data  = (state == S_IDLE) & d_req_eff;
  assign issue_fetch = (state == S_IDLE) & ~d_req_eff & (fetch_room | i_redirect);
  assign fetch_ack   = (state == S_FETCH) & i_mem_ack;
  assign data_ack    = (state == S_DATA) & i_mem_ack;
  assign fetch_drop  = fetch_ack & (kill | i_redirect);
  assign push        = fetch_ack & ~fetch_drop;
  assign pop         = o_ir_valid & i_ir_ready & ~i_redirect;

  assign byte_off = pc[OFF_W-1:0] & OFF_W'(BYTES - 1);
  assign fetch_ir = IR_W'(i_mem_rdata >> {byte_off, 3'b000});

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue_data)       state_nxt = S_DATA;
        else if (issue_fetch) state_nxt = S_FETCH;
      end
      S_FETCH: if (i_mem_ack) state_nxt = S_IDLE;
      S_DATA:  if (i_mem_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = (state != S_IDLE);
    o_ir_valid  = (count != '0);
    o_ir        = o_ir_valid ? q_ir[rd_ptr] : '0;
    o_ir_pc     = o_ir_valid ? q_pc[rd_ptr] : '0;
    o_d_done    = d_done_q;
    o_dbg_state = state;
  end

  // Memory command is latched at issue so a redirect during FETCH cannot disturb it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else if (issue_data) begin
      o_mem_we    <= i_d_we;
      o_mem_addr  <= i_d_addr & WORD_MASK;
      o_mem_wdata <= i_d_wdata;
    end else if (issue_fetch) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= (i_redirect ? i_redirect_pc : pc) & WORD_MASK;
      o_mem_wdata <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc        <= '0;
      kill      <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      if (i_redirect) pc <= i_redirect_pc;
      else if (push)  pc <= pc + PC_STEP;
      if (fetch_ack)                          kill <= 1'b0;
      else if (i_redirect && state == S_FETCH) kill <= 1'b1;
      if (issue_fetch)    in_flight <= 1'b1;
      else if (fetch_ack) in_flight <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_ir[wr_ptr] <= fetch_ir;
      q_pc[wr_ptr] <= pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      d_done_q  <= 1'b0;
      o_d_rdata <= '0;
    end else begin
      d_done_q <= data_ack;
      if (data_ack) o_d_rdata <= o_mem_we ? '0 : i_mem_rdata;
    end
  end

`ifdef UMEM_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fetch_cnt <= '0;
      o_data_cnt  <= '0;
      o_kill_cnt  <= '0;
    end else begin
      if (push && o_fetch_cnt != '1)       o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (d_done_q && o_data_cnt != '1)    o_data_cnt  <= o_data_cnt + 32'd1;
      if (fetch_drop && o_kill_cnt != '1)  o_kill_cnt  <= o_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_umem_fetch_arbiter.sv
// Bench for umem_fetch_arbiter: memory model with programmable ack latency, instruction and
// load-data scoreboards, and one task per scenario.
module tb_umem_fetch_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ir_valid;
  logic [15:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready = 1'b0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [1:0]  dbg_state;
`ifdef UMEM_PERF_EN
  logic [31:0] fetch_cnt, data_cnt, kill_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;
  int wait_cnt = 0;
  int fetch_acks = 0;
  int done_cnt = 0;
  logic [31:0] mem [1024];
  logic [47:0] exp_ir_q[$];
  logic [31:0] exp_d_q[$];

  umem_fetch_arbiter dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_ir_valid(ir_valid), .o_ir(ir), .o_ir_pc(ir_pc), .i_ir_ready(ir_ready),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_rdata(d_rdata), .o_d_done(d_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_dbg_state(dbg_state)
`ifdef UMEM_PERF_EN
    , .o_fetch_cnt(fetch_cnt), .o_data_cnt(data_cnt), .o_kill_cnt(kill_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_ir(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic predict(input logic [31:0] base, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(2 * i);
      exp_ir_q.push_back({a, model_ir(a)});
    end
  endtask

  // Memory model and output monitor; all sampling on the falling edge.
  always @(negedge clk) begin
    logic [47:0] e;
    logic [31:0] ed;
    if (!rst_n) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      if (ir_valid && ir_ready && !redirect) begin
        n_cmp++;
        if (exp_ir_q.size() == 0) begin
          n_err++;
          $display("FAIL ir_pop: got pc=%h ir=%h, required no pop", ir_pc, ir);
        end else begin
          e = exp_ir_q.pop_front();
          if ({ir_pc, ir} !== e) begin
            n_err++;
            $display("FAIL ir_pop: got pc=%h ir=%h, required pc=%h ir=%h", ir_pc, ir, e[47:16], e[15:0]);
          end
        end
      end
      if (d_done) begin
        done_cnt++;
        n_cmp++;
        if (exp_d_q.size() == 0) begin
          n_err++;
          $display("FAIL d_done: unexpected pulse rdata=%h", d_rdata);
        end else begin
          ed = exp_d_q.pop_front();
          if (d_rdata !== ed) begin
            n_err++;
            $display("FAIL d_rdata: got %h, required %h", d_rdata, ed);
          end
        end
      end
      if (mem_ack) begin
        n_cmp++;
        if (mem_req !== 1'b0) begin
          n_err++;
          $display("FAIL idle_gap: mem_req=%b in cycle after ack, required 0", mem_req);
        end
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
            if (dbg_state == 2'd1) fetch_acks++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ir_valid, ir, ir_pc, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b req=%b addr=%h rdata=%h, required all 0",
               ir_valid, mem_req, mem_addr, d_rdata);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
  endtask

  task automatic test_fill();
    bit got = 0;
    bit req_seen = 0;
    lat = 1;
    ir_ready = 1'b0;
    predict(32'h0, 32);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ir_valid) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL fill_valid: o_ir_valid never rose, required 1 within 20 cycles");
    end else begin
      n_cmp++;
      if (ir !== 16'hAAAA) begin n_err++; $display("FAIL first_ir: got %h, required aaaa", ir); end
      n_cmp++;
      if (ir_pc !== 32'h0) begin n_err++; $display("FAIL first_pc: got %h, required 0", ir_pc); end
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) req_seen = 1;
    end
    n_cmp++;
    if (req_seen) begin n_err++; $display("FAIL full_idle: mem_req=1 with full queue, required 0"); end
    n_cmp++;
    if (fetch_acks != 4) begin n_err++; $display("FAIL fill_count: got %0d fetches, required 4", fetch_acks); end
  endtask

  task automatic test_data_priority();
    bit got = 0;
    int base_done = done_cnt;
    lat = 2;
    @(posedge clk); #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = '0;
    exp_d_q.push_back(32'h12345678);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    n_cmp++;
    if ({got, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_err++;
      $display("FAIL data_first: got req=%b we=%b addr=%h, required 1 0 00000100", got, mem_we, mem_addr);
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_done) got = 1;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL load_done: no o_d_done, required pulse"); end
    @(posedge clk); #1 d_req = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    n_cmp++;
    if ({got, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h8}) begin
      n_err++;
      $display("FAIL fetch_resume: got req=%b we=%b addr=%h, required 1 0 00000008", got, mem_we, mem_addr);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt - base_done != 1) begin
      n_err++;
      $display("FAIL load_pulses: got %0d, required 1", done_cnt - base_done);
    end
  endtask

  task automatic test_store();
    bit got = 0;
    int base_done = done_cnt;
    lat = 1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    exp_d_q.push_back(32'h0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) got = 1;
    end
    n_cmp++;
    if ({got, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL store_cmd: got we=%b addr=%h wdata=%h, required 1 00000200 deadbeef", got, mem_addr, mem_wdata);
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_done) got = 1;
    end
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done_cnt - base_done != 1) begin
      n_err++;
      $display("FAIL store_pulses: got %0d, required 1", done_cnt - base_done);
    end
  endtask

  task automatic test_redirect();
    bit got = 0;
    lat = 3;
    @(posedge clk); #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we) got = 1;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL redirect_setup: no fetch in flight, required one"); end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h40;
    exp_ir_q.delete();
    predict(32'h40, 32);
    @(posedge clk); #1 redirect = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (ir_valid) got = 1;
    end
    n_cmp++;
    if ({got, ir_pc} !== {1'b1, 32'h40}) begin
      n_err++;
      $display("FAIL redirect_pc: got valid=%b pc=%h, required 1 00000040", got, ir_pc);
    end
    @(posedge clk); #1 ir_ready = 1'b1;
    repeat (16) @(posedge clk);
    #1 ir_ready = 1'b0;
  endtask

  task automatic test_full_pop_ack();
    bit got = 0;
    bit req_seen = 0;
    int base;
    lat = 3;
    repeat (30) @(posedge clk);
    #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL popack_setup: no fetch issued, required one"); end
    @(posedge clk); #1;
    @(posedge clk); #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
    base = fetch_acks;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) req_seen = 1;
    end
    n_cmp++;
    if (fetch_acks - base != 1) begin
      n_err++;
      $display("FAIL popack_occupancy: got %0d refills, required 1", fetch_acks - base);
    end
    n_cmp++;
    if (req_seen) begin n_err++; $display("FAIL popack_full: mem_req=1 after refill, required 0"); end
    @(posedge clk); #1 ir_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1 ir_ready = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    bit got = 0;
    int base_done;
    lat = 6;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h100) got = 1;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL midreset_setup: data not issued, required issue"); end
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b0;
    exp_ir_q.delete();
    base_done = done_cnt;
    #1;
    n_cmp++;
    if ({ir_valid, ir, ir_pc, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got valid=%b req=%b addr=%h rdata=%h, required all 0",
               ir_valid, mem_req, mem_addr, d_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    predict(32'h0, 32);
    lat = 1;
    rst_n = 1'b1;
    ir_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    n_cmp++;
    if ({got, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL midreset_restart: got req=%b we=%b addr=%h, required 1 0 00000000", got, mem_we, mem_addr);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (done_cnt != base_done) begin
      n_err++;
      $display("FAIL midreset_done: got %0d pulses, required 0", done_cnt - base_done);
    end
    @(posedge clk); #1 ir_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]    = 32'hBBBBAAAA;
    mem[64]   = 32'h12345678;
    test_reset();
    test_fill();
    test_data_priority();
    test_store();
    test_redirect();
    test_full_pop_ack();
    test_reset_mid_data();
    n_cmp++;
    if (exp_d_q.size() != 0) begin
      n_err++;
      $display("FAIL data_drain: got %0d outstanding, required 0", exp_d_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
